// File: rtl/sample_reader.sv
// Sample buffer read sequencer: manages write/read pointers of an external
// circular sample RAM and presents stored samples to a ready/valid consumer.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | no sample in flight; wait for a stored sample
// ST_FETCH   | issue RAM read at the read pointer
// ST_WAIT    | RAM data returns; capture into out_data
// ST_PRESENT | out_valid high until the consumer takes it
module sample_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_in,
  input  logic              flag_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              alarm,
  input  logic              clr_flags
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PRESENT
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   full;

  assign full  = (count == DEPTH);
  assign wr_en = we_in & ~full & ~rst;

  // A write in IDLE starts the fetch on the very next cycle, giving the
  // three-cycle write-to-valid latency; the RAM already holds the word then.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count != '0) || wr_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_addr  <= '0;
      rd_addr  <= '0;
      count    <= '0;
      out_data <= '0;
      overflow <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
      if (rd_en) rd_addr <= rd_addr + ADDR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (state_q == ST_WAIT) out_data <= rd_data;
      // set events take precedence over a simultaneous clear
      overflow <= (overflow & ~clr_flags) | (we_in & full);
      alarm    <= (alarm & ~clr_flags) | (wr_en & flag_in);
    end
  end

endmodule
